// File: rtl/mesh_router_rr_if.sv
// Flit handshake bundle for the 5-port mesh router (lane order N, E, S, W, PE).
// The router takes the slave side; the surrounding fabric or a bench takes the master side.
interface mesh_router_rr_if #(
  parameter int WIDTH = 33
);
  logic [5*WIDTH-1:0] in_data;
  logic [4:0]         in_valid;
  logic [4:0]         in_ready;
  logic [5*WIDTH-1:0] out_data;
  logic [4:0]         out_valid;
  logic [4:0]         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mesh_router_rr.sv
// 5-port XY mesh router: per-input FIFOs, per-output round-robin arbiters and output registers.
// Define ROUTER_STATS_EN to build the saturating per-output forwarded-flit counters.
module mesh_router_rr #(
  parameter int WIDTH  = 33,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0
) (
  input  logic                clk,
  input  logic                rst,
  mesh_router_rr_if.slave     bus,
  output logic                err_uturn,
  output logic [5*16-1:0]     stat_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [2:0] P_N  = 3'd0;
  localparam logic [2:0] P_E  = 3'd1;
  localparam logic [2:0] P_S  = 3'd2;
  localparam logic [2:0] P_W  = 3'd3;
  localparam logic [2:0] P_PE = 3'd4;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [2:0] route_of(input logic [WIDTH-1:0] flit);
    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] dy;
    dx = flit[WIDTH-1 -: ADDR_W];
    dy = flit[WIDTH-1-ADDR_W -: ADDR_W];
    if (dx > ADDR_W'(MY_X))      route_of = P_E;
    else if (dx < ADDR_W'(MY_X)) route_of = P_W;
    else if (dy < ADDR_W'(MY_Y)) route_of = P_N;
    else if (dy > ADDR_W'(MY_Y)) route_of = P_S;
    else                         route_of = P_PE;
  endfunction

  function automatic logic [2:0] next_rr(input logic [2:0] src);
    next_rr = (src == 3'd4) ? 3'd0 : src + 3'd1;
  endfunction

  logic [4:0][WIDTH-1:0] head_p0;
  logic [4:0]            head_vld_p0;
  logic [4:0][2:0]       head_route;
  logic [4:0]            drop;
  logic [4:0]            pop;
  logic [4:0][4:0]       req;
  logic [4:0]            can_load;
  logic [4:0]            out_vld;
  logic [4:0][2:0]       rr_ptr;
  logic [4:0]            grant_vld;
  logic [4:0][2:0]       grant_src;
  logic [4:0][WIDTH-1:0] grant_data;

  // Stage p0: input FIFOs; in_ready depends only on the registered occupancy.
  for (genvar gi = 0; gi < 5; gi++) begin : g_in
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             full;
    logic             push_w;
    logic             pop_w;

    assign full            = (cnt_q == (PTR_W+1)'(DEPTH));
    assign push_w          = bus.in_valid[gi] & ~full;
    assign pop_w           = pop[gi] & (cnt_q != '0);
    assign bus.in_ready[gi] = ~full;
    assign head_vld_p0[gi] = (cnt_q != '0);
    assign head_p0[gi]     = mem[rd_q];
    assign head_route[gi]  = route_of(mem[rd_q]);

    // A cardinal input whose head routes back out of the same port is a U-turn.
    if (gi < 4) begin : g_uturn
      assign drop[gi] = (cnt_q != '0) && (route_of(mem[rd_q]) == 3'(gi));
    end else begin : g_pe
      assign drop[gi] = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (push_w) mem[wr_q] <= bus.in_data[gi*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push_w) wr_q <= wr_q + 1'b1;
        if (pop_w)  rd_q <= rd_q + 1'b1;
        case ({push_w, pop_w})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  for (genvar go = 0; go < 5; go++) begin : g_req_o
    for (genvar gr = 0; gr < 5; gr++) begin : g_req_i
      assign req[go][gr] = head_vld_p0[gr] & ~drop[gr] & (head_route[gr] == 3'(go));
    end
    assign can_load[go] = ~out_vld[go] | bus.out_ready[go];
  end

  // Round-robin: first pass scans rr_ptr..4, second pass wraps over 0..rr_ptr-1.
  always_comb begin
    grant_vld  = '0;
    grant_src  = '0;
    grant_data = '0;
    pop        = drop;
    for (int o = 0; o < 5; o++) begin
      if (can_load[o]) begin
        for (int pass = 0; pass < 2; pass++) begin
          for (int i = 0; i < 5; i++) begin
            if (!grant_vld[o] && req[o][i] && ((pass == 0) == (3'(i) >= rr_ptr[o]))) begin
              grant_vld[o]  = 1'b1;
              grant_src[o]  = 3'(i);
              grant_data[o] = head_p0[i];
              pop[i]        = 1'b1;
            end
          end
        end
      end
    end
  end

  // Stage p1: output registers hold their flit until the downstream handshake.
  for (genvar go = 0; go < 5; go++) begin : g_out
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [2:0]       rr_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
        rr_q    <= '0;
      end else if (grant_vld[go]) begin
        vld_p1  <= 1'b1;
        data_p1 <= grant_data[go];
        rr_q    <= next_rr(grant_src[go]);
      end else if (bus.out_ready[go]) begin
        vld_p1  <= 1'b0;
      end
    end

    assign out_vld[go]                       = vld_p1;
    assign rr_ptr[go]                        = rr_q;
    assign bus.out_valid[go]                 = vld_p1;
    assign bus.out_data[go*WIDTH +: WIDTH]   = data_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        err_uturn <= 1'b0;
    else if (|drop) err_uturn <= 1'b1;
  end

`ifdef ROUTER_STATS_EN
  for (genvar so = 0; so < 5; so++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (out_vld[so] && bus.out_ready[so] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign stat_count[so*16 +: 16] = cnt_q;
  end
`else
  assign stat_count = '0;
`endif
endmodule
